// File: rtl/traffic_ctrl_gen.sv
// Purpose : multi-approach traffic-light controller; one shared phase sequencer drives all approaches.
// Latency : lamps are a zero-latency combinational decode of registered state/phase/timer/grant.
// Backpressure: none; en=0 freezes the sequence, while pedestrian requests keep latching.
//
// Optional feature macro: TRAFFIC_PED_REQ_EN. When it is defined, the walk is granted only on request.
//   Otherwise ped_req is ignored, o_ped_pend reads 0 and every green grants the walk.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           advance enable (low holds state, phase, timer and grant)
//   ped_req      per-phase pedestrian button, level-sampled
//   o_car        per-phase car lamp, 2 bits per phase (01 green, 10 yellow, 11 red)
//   o_ped        per-phase pedestrian lamp, 2 bits per phase (01 walk, 00 don't-walk)
//   o_phase      active phase index
//   o_state      00 GREEN, 01 YELLOW, 10 ALL_RED
//   o_timer      cycles elapsed in the current state
//   o_ped_pend   latched, unserved pedestrian requests
module traffic_ctrl_gen #(
  parameter int N_PHASE  = 4,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 10,
  parameter int T_FLASH  = 6,
  localparam int PW      = $clog2(N_PHASE),
  localparam int T_GY    = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW,
  localparam int T_MAX   = (T_GY > T_ALLRED) ? T_GY : T_ALLRED,
  localparam int TW      = $clog2(T_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N_PHASE-1:0]     ped_req,
  output logic [2*N_PHASE-1:0]   o_car,
  output logic [2*N_PHASE-1:0]   o_ped,
  output logic [PW-1:0]          o_phase,
  output logic [1:0]             o_state,
  output logic [TW-1:0]          o_timer,
  output logic [N_PHASE-1:0]     o_ped_pend
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } state_t;

  localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASE - 1);
  localparam logic [TW-1:0] G_LAST     = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] Y_LAST     = TW'(T_YELLOW - 1);
  // ALL_RED is never entered when T_ALLRED is 0, so its compare value is then irrelevant.
  localparam logic [TW-1:0] R_LAST     = (T_ALLRED > 0) ? TW'(T_ALLRED - 1) : '0;
  localparam bit            WALK_ODD   = (T_WALK % 2) == 1;

  state_t          state_q;
  logic [PW-1:0]   phase_q;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   t_last;
  logic            last_tick;
  logic            enter_green;
  logic [PW-1:0]   phase_inc;
  logic            grant;

  always_comb begin
    t_last = G_LAST;
    case (state_q)
      ST_GREEN:  t_last = G_LAST;
      ST_YELLOW: t_last = Y_LAST;
      ST_ALLRED: t_last = R_LAST;
      default:   t_last = G_LAST;
    endcase
  end

  assign last_tick = en && (timer_q == t_last);
  assign phase_inc = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;

  // The edge that starts the next phase's green: end of ALL_RED, or end of
  // YELLOW when the all-red clearance is configured away.
  assign enter_green = last_tick &&
                       ((state_q == ST_ALLRED) || ((state_q == ST_YELLOW) && (T_ALLRED == 0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GREEN;
      phase_q <= '0;
      timer_q <= '0;
    end else if (en) begin
      if (last_tick) begin
        timer_q <= '0;
        case (state_q)
          ST_GREEN: state_q <= ST_YELLOW;
          ST_YELLOW: begin
            if (T_ALLRED == 0) begin
              state_q <= ST_GREEN;
              phase_q <= phase_inc;
            end else begin
              state_q <= ST_ALLRED;
            end
          end
          ST_ALLRED: begin
            state_q <= ST_GREEN;
            phase_q <= phase_inc;
          end
          default: state_q <= ST_GREEN;
        endcase
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

`ifdef TRAFFIC_PED_REQ_EN
  logic [N_PHASE-1:0] pend_q, pend_d;
  logic               grant_q, grant_d;

  // Requests latch regardless of en. On entry to a green, the phase's pending bit
  // (or a same-cycle press) becomes the walk grant and the pending bit is consumed.
  // A press during the phase's own green re-latches and waits for its next green.
  always_comb begin
    pend_d  = pend_q | ped_req;
    grant_d = grant_q;
    if (enter_green) begin
      grant_d            = pend_q[phase_inc] | ped_req[phase_inc];
      pend_d[phase_inc]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      grant_q <= grant_d;
    end
  end

  assign grant      = grant_q;
  assign o_ped_pend = pend_q;
`else
  logic unused_ped;
  assign unused_ped = ^{ped_req, enter_green};
  assign grant      = 1'b1;
  assign o_ped_pend = '0;
`endif

  always_comb begin
    o_car = '1;
    for (int k = 0; k < N_PHASE; k++) begin
      if (PW'(k) == phase_q) begin
        if (state_q == ST_GREEN)       o_car[2*k +: 2] = 2'b01;
        else if (state_q == ST_YELLOW) o_car[2*k +: 2] = 2'b10;
      end
    end
  end

  // Walk is steady for T_WALK cycles, then flashes on (timer-T_WALK) parity.
  always_comb begin
    o_ped = '0;
    for (int k = 0; k < N_PHASE; k++) begin
      if ((PW'(k) == phase_q) && (state_q == ST_GREEN) && grant) begin
        if (int'(timer_q) < T_WALK)
          o_ped[2*k +: 2] = 2'b01;
        else if (int'(timer_q) < T_WALK + T_FLASH)
          o_ped[2*k +: 2] = {1'b0, ~(timer_q[0] ^ WALK_ODD)};
      end
    end
  end

  assign o_phase = phase_q;
  assign o_state = state_q;
  assign o_timer = timer_q;

endmodule

// File: tb/tb_traffic_ctrl_gen.sv
// Directed bench for traffic_ctrl_gen: default instance plus a 2-phase, no-all-red instance.
module tb_traffic_ctrl_gen;

`ifdef TRAFFIC_PED_REQ_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] ped_req;

  logic [7:0] o_car, o_ped;
  logic [1:0] o_phase, o_state;
  logic [4:0] o_timer;
  logic [3:0] o_ped_pend;

  logic [1:0] ped_req_b;
  logic [3:0] o_car_b, o_ped_b;
  logic [0:0] o_phase_b;
  logic [1:0] o_state_b;
  logic [4:0] o_timer_b;
  logic [1:0] o_ped_pend_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  traffic_ctrl_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
    .o_car(o_car), .o_ped(o_ped), .o_phase(o_phase), .o_state(o_state),
    .o_timer(o_timer), .o_ped_pend(o_ped_pend)
  );

  traffic_ctrl_gen #(.N_PHASE(2), .T_ALLRED(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req_b),
    .o_car(o_car_b), .o_ped(o_ped_b), .o_phase(o_phase_b), .o_state(o_state_b),
    .o_timer(o_timer_b), .o_ped_pend(o_ped_pend_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pedestrian lamp for a granted green, by cycles into that green.
  function automatic logic [1:0] ped_pat(input int t);
    if (t < 10)      return 2'b01;
    else if (t < 16) return ((t - 10) % 2 == 0) ? 2'b01 : 2'b00;
    else             return 2'b00;
  endfunction

  function automatic logic [1:0] car0_pat(input int t);
    if (t < 20)      return 2'b01;
    else if (t < 23) return 2'b10;
    else             return 2'b11;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    ped_req   = '0;
    ped_req_b = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    en    = 1'b1;

    // Full 100-cycle sequence from reset, cycle c sampled at the negedge after c enabled edges.
    for (int c = 0; c <= 100; c++) begin
      if (c > 0) tick();
      ped_req = (c == 30) ? 4'b0100 : 4'b0000;

      if (c == 0) begin
        chk("rst_car",   o_car,      8'hFD);
        chk("rst_ped",   o_ped,      PED_EN ? 8'h00 : 8'h01);
        chk("rst_phase", o_phase,    2'd0);
        chk("rst_state", o_state,    2'd0);
        chk("rst_timer", o_timer,    5'd0);
        chk("rst_pend",  o_ped_pend, 4'h0);
        chk("b_rst_car", o_car_b,    4'hD);
      end
      if (c <= 24) begin
        chk("car0_seq", o_car[1:0], car0_pat(c));
        chk("ped0_seq", o_ped[1:0], PED_EN ? 2'b00 : ped_pat(c));
      end
      if (c == 20) begin
        chk("yel_state", o_state, 2'd1);
        chk("yel_timer", o_timer, 5'd0);
      end
      if (c == 23) chk("ar_state", o_state, 2'd2);
      if (c == 24) chk("ar_timer", o_timer, 5'd1);
      if (c == 25) begin
        chk("p1_phase", o_phase, 2'd1);
        chk("p1_car",   o_car,   8'hF7);
        chk("p1_state", o_state, 2'd0);
        chk("p1_timer", o_timer, 5'd0);
      end
      if (c == 22) chk("b_yel_state", o_state_b, 2'd1);
      if (c == 23) begin
        chk("b_p1_phase", o_phase_b, 1'b1);
        chk("b_p1_state", o_state_b, 2'd0);
        chk("b_p1_car",   o_car_b,   4'h7);
      end
      if (c == 46) begin
        chk("b_wrap_phase", o_phase_b, 1'b0);
        chk("b_wrap_state", o_state_b, 2'd0);
        chk("b_wrap_timer", o_timer_b, 5'd0);
      end
      if (c == 31 || c == 49) chk("pend2_set", o_ped_pend, PED_EN ? 4'b0100 : 4'b0000);
      if (c == 50) begin
        chk("p2_phase", o_phase,    2'd2);
        chk("p2_pend",  o_ped_pend, 4'b0000);
      end
      if (c >= 50 && c <= 74) chk("ped2_seq", o_ped[5:4], ped_pat(c - 50));
      if (c >= 75 && c <= 99) chk("ped3_seq", o_ped[7:6], PED_EN ? 2'b00 : ped_pat(c - 75));
      if (c == 99) begin
        chk("p3_phase", o_phase, 2'd3);
        chk("p3_state", o_state, 2'd2);
        chk("p3_timer", o_timer, 5'd1);
      end
      if (c == 100) begin
        chk("wrap_phase", o_phase, 2'd0);
        chk("wrap_state", o_state, 2'd0);
        chk("wrap_timer", o_timer, 5'd0);
        chk("wrap_car",   o_car,   8'hFD);
      end
    end

    // Hold at timer 12 of green for 5 cycles; requests still latch while held.
    repeat (12) tick();
    chk("pre_hold_timer", o_timer, 5'd12);
    en      = 1'b0;
    ped_req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_timer", o_timer,    5'd12);
      chk("hold_state", o_state,    2'd0);
      chk("hold_car",   o_car,      8'hFD);
      chk("hold_ped",   o_ped[1:0], PED_EN ? 2'b00 : 2'b01);
    end
    chk("hold_pend", o_ped_pend, PED_EN ? 4'b0010 : 4'b0000);
    en      = 1'b1;
    ped_req = 4'b0000;
    repeat (7) tick();
    chk("rel_timer", o_timer, 5'd19);
    chk("rel_state", o_state, 2'd0);
    tick();
    chk("rel_yel_state", o_state, 2'd1);
    chk("rel_yel_timer", o_timer, 5'd0);

    // Asynchronous reset mid-yellow, checked between clock edges.
    rst_n = 1'b0;
    #1;
    chk("arst_car",   o_car,      8'hFD);
    chk("arst_state", o_state,    2'd0);
    chk("arst_timer", o_timer,    5'd0);
    chk("arst_pend",  o_ped_pend, 4'h0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Restart, run to cycle 60, then reset again for two cycles.
    for (int c = 1; c <= 60; c++) begin
      tick();
      ped_req = (c == 55) ? 4'b1000 : 4'b0000;
    end
    chk("c60_phase", o_phase,    2'd2);
    chk("c60_state", o_state,    2'd0);
    chk("c60_timer", o_timer,    5'd10);
    chk("c60_pend",  o_ped_pend, PED_EN ? 4'b1000 : 4'b0000);
    rst_n = 1'b0;
    #1;
    chk("c60_rst_car",   o_car,      8'hFD);
    chk("c60_rst_phase", o_phase,    2'd0);
    chk("c60_rst_timer", o_timer,    5'd0);
    chk("c60_rst_pend",  o_ped_pend, 4'h0);
    chk("c60_rst_ped",   o_ped[1:0], PED_EN ? 2'b00 : 2'b01);
    repeat (2) tick();
    rst_n = 1'b1;
    chk("restart_timer0", o_timer, 5'd0);
    tick();
    chk("restart_timer1", o_timer, 5'd1);
    chk("restart_car",    o_car,   8'hFD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_gen.md
# traffic_ctrl_gen

Parametrised multi-approach traffic-light controller, the successor to the fixed two-axis, 68-cycle intersection controller. One instance drives every approach of an intersection from a single shared phase sequencer, so the approaches cannot desynchronise. Phase durations and the approach count are parameters. The block adds an enable/hold input and an optional pedestrian push-button request path.

## Interface
- N_PHASE, 4: number of approach groups served in round-robin order, ≥2
- T_GREEN, 20: car green cycles per phase, ≥1
- T_YELLOW, 3: car yellow cycles, ≥1
- T_ALLRED, 2: all-red clearance cycles after yellow; 0 skips the ALL_RED state
- T_WALK, 10: pedestrian steady-walk cycles at start of green
- T_FLASH, 6: pedestrian flashing cycles after walk; T_WALK+T_FLASH ≤ T_GREEN
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  advance enable; low freezes the sequence
- ped_req  in  N_PHASE  per-phase pedestrian button, level sampled each clk
- o_car  out  2*N_PHASE  per-phase car lamp, slice k = [2k+1:2k]; 01 green, 10 yellow, 11 red
- o_ped  out  2*N_PHASE  per-phase pedestrian lamp; 01 walk, 00 don't-walk
- o_phase  out  $clog2(N_PHASE)  active phase index
- o_state  out  2  00 GREEN, 01 YELLOW, 10 ALL_RED
- o_timer  out  $clog2(max(T_*)+1)  cycles elapsed in current state
- o_ped_pend  out  N_PHASE  latched, unserved pedestrian requests

## Operation
- FSM GREEN → YELLOW → ALL_RED → GREEN (phase+1). With T_ALLRED=0, YELLOW goes directly to GREEN (phase+1).
- The phase index wraps N_PHASE-1 → 0.
- Timer starts at 0 on state entry and increments on each clk with en=1. When the timer equals T_state-1 and en=1, the state transitions and the timer clears.
- Car lamps: the active phase shows 01 in GREEN and 10 in YELLOW. Every other phase shows 11. In ALL_RED every phase shows 11.
- Pedestrian lamp k applies only while phase k is in GREEN and the walk is granted:
  - timer < T_WALK → 01
  - T_WALK ≤ timer < T_WALK+T_FLASH → 01 when (timer-T_WALK) is even, 00 when odd
  - later → 00
- All other pedestrian lamps are 00.
- Walk grant: unconditional unless TRAFFIC_PED_REQ_EN is defined (see Configuration).
- Outputs are combinational decodes of the registered state, phase, timer and grant flag. No glitch-free guarantee beyond that.
- en=0: state, phase, timer and grant are held. Lamps hold their values, including the flash level. Request latching continues.

## Timing
- Reset values: state GREEN, phase 0, timer 0.
- Outputs at reset: o_car slice0=01, all other slices 11; o_ped slice0=01 (00 with macro); o_ped_pend=0.
- Full cycle period = N_PHASE*(T_GREEN+T_YELLOW+T_ALLRED) enabled clocks; 100 with defaults.
- Zero-latency decode: lamps change in the same cycle as the state/timer register edge.
- Reset assertion mid-sequence returns to the reset state immediately, asynchronously. Pending requests are cleared. The first enabled edge after release increments the timer from 0.
- Timer width covers max(T_GREEN, T_YELLOW, T_ALLRED)-1. There is no overflow, because the compare clears the timer first.

## Configuration
- TRAFFIC_PED_REQ_EN defined:
  - ped_req[k] sets the sticky bit o_ped_pend[k].
  - On entry to GREEN of phase k, grant = pend[k] | ped_req[k]. On that same edge, pend[k] clears.
  - A request asserted during phase k's own GREEN stays pending for its next green.
  - Without a grant, o_ped slice k stays 00 for the whole green.
  - Phase 0 after reset has no grant.
- Undefined: ped_req is ignored, o_ped_pend is tied to 0, and every green grants the walk.

## Test plan
- Reset then en=1 with defaults:
  - o_car[1:0] = 01 for cycles 0–19, 10 for 20–22, 11 for 23–24.
  - o_phase=1 and o_car[3:2]=01 at cycle 25.
  - o_phase wraps 3→0 at cycle 100.
- Pedestrian decode, macro undefined: o_ped[1:0] = 01 for cycles 0–9, then 01,00,01,00,01,00 for cycles 10–15, then 00 for cycles 16–24.
- T_ALLRED=0, N_PHASE=2: after yellow cycle 22, cycle 23 shows phase 1 green. Period is 46.
- en=0 for 5 cycles at timer=12 of GREEN: all outputs frozen. On release, yellow starts 8 enabled cycles later.
- Macro defined:
  - Pulse ped_req[2] at cycle 30: o_ped_pend[2]=1.
  - Phase 2 green at cycle 50 walks, and pend[2] clears.
  - Phase 3 with no request: o_ped[7:6]=00 throughout.
- rst_n low at cycle 60 for 2 cycles: the outputs return to the reset values immediately and the sequence restarts from cycle 0.
